sub_bytes_reader: RTL
=====================

# sub_bytes_reader

Read-side companion to the S-box RAM initializer. Once the initializer raises `ram_ready`, this block accepts a 128-bit AES state over a valid/ready handshake. It then performs SubBytes by issuing 16 sequential byte lookups on the S-box RAM read port, and returns the substituted state over a second valid/ready handshake. It sits between the round-key/AddRoundKey stage and ShiftRows in the encryption datapath.

## Interface
Parameters:
- `RD_LAT`, default 1: RAM read latency in clocks, legal range 1–3.
- `NBYTES`, default 16: bytes per state. Fixed at 16; it is a parameter for readability only.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `ram_ready`, input, 1: S-box RAM fully written; level signal.
- `in_valid`, input, 1: `in_state` is valid.
- `in_ready`, output, 1: block can accept a state.
- `in_state`, input, [0:127]: byte k occupies bits [8k:8k+7]; byte 0 is bits [0:7].
- `rd_enable`, output, 1: RAM read strobe.
- `rd_addr`, output, [0:7]: RAM read address, which is the input byte value.
- `rd_data`, input, [0:7]: RAM read data, valid `RD_LAT` clocks after the address is sampled.
- `out_valid`, output, 1: `out_state` is valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_state`, output, [0:127]: substituted state, using the same byte order as `in_state`.

## Operation
- State machine states: WAIT_RAM, IDLE, ISSUE, DRAIN, HOLD.
- WAIT_RAM is the reset state. All handshake outputs are low. The FSM moves to IDLE when `ram_ready` is 1.
- IDLE: `in_ready` = 1. When `in_valid` and `in_ready` are both high, the block captures `in_state` into an input register, clears the issue index to 0, and moves to ISSUE.
- ISSUE:
  - `rd_enable` = 1 and `rd_addr` = input byte[idx].
  - idx increments every clock.
  - After idx = 15 is issued, the FSM moves to DRAIN.
- Capture: a tag pipeline of depth `RD_LAT` carries (valid, idx). When the tag emerges, `rd_data` is written into output byte[idx].
- DRAIN: the FSM waits until the capture for byte 15 has been written, then moves to HOLD.
- HOLD:
  - `out_valid` = 1 and `out_state` is held stable.
  - When `out_valid` and `out_ready` are both high, the FSM returns to IDLE.
  - There is no overlap of blocks: `in_ready` = 0 in every state except IDLE.
- `ram_ready` deasserted in any state other than WAIT_RAM:
  - The in-flight block is discarded.
  - The tag pipeline is flushed.
  - `out_valid` drops on the next clock and the FSM goes to WAIT_RAM.
- `reset` low at any time: all registers clear immediately, including mid-ISSUE and mid-HOLD.
- Reset values:
  - `in_ready` = 0, `rd_enable` = 0, `rd_addr` = 8'h00, `out_valid` = 0.
  - `out_state` = 128'h0.
  - idx = 0 and all tags are invalid.

## Timing
- The accept edge is E0. Byte k is presented in the cycle after E(k) and sampled by the RAM at E(k+1).
- The capture for byte k happens at E(k+1+`RD_LAT`).
- `out_valid` rises after E(16+`RD_LAT`), which is 17 clocks after accept when `RD_LAT` = 1.
- `rd_enable` is high for exactly 16 consecutive cycles per block.
- `in_ready` returns high in the cycle after the output handshake completes.
- Peak throughput is one block per 18 + `RD_LAT` clocks when `out_ready` is tied to 1.
- `out_ready` held low keeps the FSM in HOLD indefinitely. `out_state` must not change while in HOLD.
- `in_valid` asserted during WAIT_RAM is ignored, not queued.

## Configuration
- `SUB_BYTES_DONE_CNT_EN` defined:
  - Adds an output port `done_count`, [0:15].
  - The counter increments on each output handshake, wraps from 16'hFFFF to 0, and resets to 0.
  - It is not cleared by a `ram_ready` drop.
- `SUB_BYTES_DONE_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `sub_bytes_pkg` contains:
  - the FSM state enum `sb_state_t`;
  - `SB_NBYTES` = 16;
  - `SB_IDX_W` = 4;
  - `SB_STATE_W` = 128.
- One sub-module, `sbox_rd_tag_pipe`: an `RD_LAT`-deep shift register of {valid, idx[0:3]} with a synchronous flush input.
- The top level holds the FSM, the input and output registers, and the capture decode.

## Test plan
- Reset release with `ram_ready` = 0 for 50 clocks, while `in_valid` = 1 -> `in_ready` stays 0 and `rd_enable` stays 0. `ram_ready` then goes to 1 -> `in_ready` = 1 the next clock.
- Behavioural RAM preloaded with the standard S-box, `in_state` = 128'h00112233445566778899aabbccddeeff -> `out_state` = 128'h638293c31bfc33f5c4eeacea4bc12816, with `out_valid` asserted exactly 17 clocks after accept.
- `RD_LAT` = 3, all-zero state -> `out_state` = 128'h63636363636363636363636363636363 after 19 clocks.
- `out_ready` held low for 40 clocks -> `out_valid` stays 1 with `out_state` stable and `in_ready` = 0. The block completes on the first `out_ready` = 1.
- `ram_ready` dropped at issue index 7 -> `out_valid` never rises for that block and the FSM returns to WAIT_RAM. After re-raise, a fresh block completes correctly.
- `reset` asserted mid-HOLD -> all outputs go to 0 asynchronously. With `SUB_BYTES_DONE_CNT_EN` defined, 3 blocks complete -> `done_count` = 3.

Source files
------------

// File: rtl/sub_bytes_pkg.sv
// Shared types and constants for the SubBytes reader datapath.
package sub_bytes_pkg;

    localparam int unsigned SB_NBYTES  = 16;
    localparam int unsigned SB_IDX_W   = 4;
    localparam int unsigned SB_STATE_W = 128;

    typedef enum logic [2:0] {
        StWaitRam = 3'd0,
        StIdle    = 3'd1,
        StIssue   = 3'd2,
        StDrain   = 3'd3,
        StHold    = 3'd4
    } sb_state_t;

    // Bit offset of byte idx within a [0:127] state vector.
    function automatic logic [6:0] sb_byte_base(input logic [0:SB_IDX_W-1] idx);
        return {idx, 3'b000};
    endfunction

endpackage

// File: rtl/sbox_rd_tag_pipe.sv
// Depth-stage shift register of {valid, idx} tracking outstanding S-box RAM reads.
module sbox_rd_tag_pipe
    import sub_bytes_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push_valid,
    input  logic [0:SB_IDX_W-1] push_idx,
    output logic                pop_valid,
    output logic [0:SB_IDX_W-1] pop_idx
);

    logic                valid_q [Depth];
    logic [0:SB_IDX_W-1] idx_q   [Depth];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
                idx_q[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
                idx_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= push_valid;
            idx_q[0]   <= push_idx;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign pop_valid = valid_q[Depth-1];
    assign pop_idx   = idx_q[Depth-1];

endmodule

// File: rtl/sub_bytes_reader.sv
// SubBytes over 16 sequential S-box RAM lookups, bracketed by two valid/ready handshakes.
// Define SUB_BYTES_DONE_CNT_EN to add the done_count output-handshake counter port.
module sub_bytes_reader
    import sub_bytes_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned NBYTES = SB_NBYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:SB_STATE_W-1] in_state,
    output logic                  rd_enable,
    output logic [0:7]            rd_addr,
    input  logic [0:7]            rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:SB_STATE_W-1] out_state
`ifdef SUB_BYTES_DONE_CNT_EN
    ,
    output logic [0:15]           done_count
`endif
);

    localparam logic [0:SB_IDX_W-1] LastIdx = SB_IDX_W'(NBYTES - 1);

    sb_state_t             state_q, state_d;
    logic [0:SB_IDX_W-1]   idx_q;
    logic [0:SB_STATE_W-1] in_q;
    logic [0:SB_STATE_W-1] out_q;
    logic                  flush;
    logic                  accept;
    logic                  tag_valid;
    logic [0:SB_IDX_W-1]   tag_idx;

    // Losing the RAM mid-block abandons the block and any reads still in flight.
    assign flush     = (state_q != StWaitRam) && !ram_ready;
    assign in_ready  = (state_q == StIdle);
    assign accept    = in_ready && in_valid;
    assign rd_enable = (state_q == StIssue);
    assign rd_addr   = rd_enable ? in_q[sb_byte_base(idx_q) +: 8] : 8'h00;
    assign out_valid = (state_q == StHold);
    assign out_state = out_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitRam: if (ram_ready) state_d = StIdle;
            StIdle:    if (in_valid) state_d = StIssue;
            StIssue:   if (idx_q == LastIdx) state_d = StDrain;
            StDrain:   if (tag_valid && (tag_idx == LastIdx)) state_d = StHold;
            StHold:    if (out_ready) state_d = StIdle;
            default:   state_d = StWaitRam;
        endcase
        if (flush) state_d = StWaitRam;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StWaitRam;
            idx_q   <= '0;
            in_q    <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                idx_q <= '0;
            end else if (accept) begin
                in_q  <= in_state;
                idx_q <= '0;
            end else if (rd_enable) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    sbox_rd_tag_pipe #(
        .Depth (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (rd_enable),
        .push_idx   (idx_q),
        .pop_valid  (tag_valid),
        .pop_idx    (tag_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else if (tag_valid && !flush) begin
            out_q[sb_byte_base(tag_idx) +: 8] <= rd_data;
        end
    end

`ifdef SUB_BYTES_DONE_CNT_EN
    logic [0:15] done_cnt_q;

    // Survives ram_ready drops; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign done_count = done_cnt_q;
`endif

endmodule
